// File: rtl/banked_registerfile_pkg.sv
// bexkat1_regfile_pkg: lane codes, clear-FSM states and lane alignment shared by the register file.
package bexkat1_regfile_pkg;

    localparam int MAXW = 64;

    typedef enum logic [1:0] {LANE_NONE, LANE_BYTE, LANE_HALF, LANE_WORD} lane_e;

    typedef enum logic [1:0] {CLR_IDLE, CLR_RUN, CLR_DONE} clr_state_e;

    // Zero-extends the selected lane; callers gate LANE_NONE themselves.
    function automatic logic [MAXW-1:0] align(lane_e code, logic [MAXW-1:0] v);
        return code == LANE_BYTE ? {{(MAXW-8){1'b0}}, v[7:0]} :
               code == LANE_HALF ? {{(MAXW-16){1'b0}}, v[15:0]} : v;
    endfunction

endpackage

// File: rtl/banked_registerfile_if.sv
// banked_registerfile_if: decode/writeback/clear bus of the banked register file.
// Parameters must match those of the banked_registerfile instance it connects to.
interface banked_registerfile_if #(
    parameter int WIDTH  = 32,
    parameter int COUNTP = 4,
    parameter int NREAD  = 3,
    parameter int BANKP  = 1
);
    logic                    supervisor;
    logic [BANKP-1:0]        bank_sel;
    logic [NREAD*COUNTP-1:0] rd_addr;
    logic [NREAD*WIDTH-1:0]  rd_data;
    logic [COUNTP-1:0]       wr_addr;
    logic [WIDTH-1:0]        wr_data;
    logic [1:0]              wr_en;
    logic [WIDTH-1:0]        sp_data_i;
    logic [1:0]              sp_en;
    logic [WIDTH-1:0]        sp_data_o;
    logic                    clr_req;
    logic [BANKP-1:0]        clr_bank;
    logic                    clr_busy;
    logic                    clr_done;

    modport master (
        output supervisor, bank_sel, rd_addr, wr_addr, wr_data, wr_en,
               sp_data_i, sp_en, clr_req, clr_bank,
        input  rd_data, sp_data_o, clr_busy, clr_done
    );

    modport slave (
        input  supervisor, bank_sel, rd_addr, wr_addr, wr_data, wr_en,
               sp_data_i, sp_en, clr_req, clr_bank,
        output rd_data, sp_data_o, clr_busy, clr_done
    );
endinterface

// File: rtl/banked_registerfile_clear_seq.sv
// regfile_clear_seq: walks one bank index per cycle emitting zero-write strobes, then pulses done.
module regfile_clear_seq
    import bexkat1_regfile_pkg::*;
#(
    parameter int COUNTP = 4,
    parameter int BANKP  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req,
    input  logic [BANKP-1:0]  i_bank,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_we,
    output logic [BANKP-1:0]  o_bank,
    output logic [COUNTP-1:0] o_idx
);
    clr_state_e        r_state, w_state;
    logic [COUNTP-1:0] r_idx, w_idx;
    logic [BANKP-1:0]  r_bank, w_bank;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= CLR_IDLE;
            r_idx   <= '0;
            r_bank  <= '0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_bank  <= w_bank;
        end
    end

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_bank  = r_bank;
        case (r_state)
            CLR_IDLE: if (i_req) begin
                w_state = CLR_RUN;
                w_idx   = '0;
                w_bank  = i_bank;
            end
            CLR_RUN: begin
                w_state = &r_idx ? CLR_DONE : CLR_RUN;
                w_idx   = r_idx + 1'b1;
            end
            default: w_state = CLR_IDLE;
        endcase
    end

    assign o_we   = r_state == CLR_RUN;
    assign o_busy = r_state != CLR_IDLE;
    assign o_done = r_state == CLR_DONE;
    assign o_bank = r_bank;
    assign o_idx  = r_idx;
endmodule

// File: rtl/banked_registerfile.sv
// banked_registerfile: NBANK register banks plus supervisor SP, lane writes, SP port and bank clear.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports and sp_data_o.
module banked_registerfile
    import bexkat1_regfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int COUNTP = 4,
    parameter int SPREG  = 15,
    parameter int NREAD  = 3,
    parameter int BANKP  = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    banked_registerfile_if.slave bus
);
    localparam int COUNT = 2**COUNTP;
    localparam int NBANK = 2**BANKP;
    localparam logic [COUNTP-1:0] SP_IDX = COUNTP'(SPREG);

    logic [WIDTH-1:0]  r_bank [NBANK][COUNT];
    logic [WIDTH-1:0]  r_ssp;
    logic [WIDTH-1:0]  w_wr_val, w_sp_val, w_sp_st;
    logic              w_wr, w_sp, w_wr_ssp;
    logic              w_clr_we;
    logic [BANKP-1:0]  w_clr_bank;
    logic [COUNTP-1:0] w_clr_idx;
    logic [COUNTP-1:0] w_ra [NREAD];
    logic [WIDTH-1:0]  w_st [NREAD];
    logic [WIDTH-1:0]  w_rv [NREAD];

    assign w_wr     = bus.wr_en != 2'd0;
    assign w_sp     = bus.sp_en != 2'd0;
    assign w_wr_val = WIDTH'(align(lane_e'(bus.wr_en), MAXW'(bus.wr_data)));
    assign w_sp_val = WIDTH'(align(lane_e'(bus.sp_en), MAXW'(bus.sp_data_i)));
    assign w_wr_ssp = bus.supervisor && bus.wr_addr == SP_IDX;

    regfile_clear_seq #(.COUNTP(COUNTP), .BANKP(BANKP)) u_clr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_req  (bus.clr_req),
        .i_bank (bus.clr_bank),
        .o_busy (bus.clr_busy),
        .o_done (bus.clr_done),
        .o_we   (w_clr_we),
        .o_bank (w_clr_bank),
        .o_idx  (w_clr_idx)
    );

    // Later assignments take precedence: clear < general write < SP write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ssp <= '0;
            for (int b = 0; b < NBANK; b++)
                for (int i = 0; i < COUNT; i++)
                    r_bank[b][i] <= '0;
        end else begin
            if (w_clr_we)
                r_bank[w_clr_bank][w_clr_idx] <= '0;
            if (w_wr && w_wr_ssp)
                r_ssp <= w_wr_val;
            else if (w_wr)
                r_bank[bus.bank_sel][bus.wr_addr] <= w_wr_val;
            if (w_sp && bus.supervisor)
                r_ssp <= w_sp_val;
            else if (w_sp)
                r_bank[bus.bank_sel][SP_IDX] <= w_sp_val;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        assign w_ra[k] = bus.rd_addr[k*COUNTP +: COUNTP];
        assign w_st[k] = (bus.supervisor && w_ra[k] == SP_IDX) ? r_ssp : r_bank[bus.bank_sel][w_ra[k]];
`ifdef REGFILE_BYPASS_EN
        assign w_rv[k] = (w_sp && w_ra[k] == SP_IDX) ? w_sp_val :
                         (w_wr && w_ra[k] == bus.wr_addr) ? w_wr_val : w_st[k];
`else
        assign w_rv[k] = w_st[k];
`endif
    end

    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < NREAD; k++)
            bus.rd_data[k*WIDTH +: WIDTH] = w_rv[k];
    end

    assign w_sp_st = bus.supervisor ? r_ssp : r_bank[bus.bank_sel][SP_IDX];
`ifdef REGFILE_BYPASS_EN
    assign bus.sp_data_o = w_sp ? w_sp_val : (w_wr && bus.wr_addr == SP_IDX) ? w_wr_val : w_sp_st;
`else
    assign bus.sp_data_o = w_sp_st;
`endif
endmodule

// File: tb/tb_banked_registerfile.sv
// tb_banked_registerfile: directed stimulus checked every cycle against an array-based model of the register file.
module tb_banked_registerfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    banked_registerfile_if bus ();
    banked_registerfile dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [31:0] mb [2][16];
    logic [31:0] mssp = 32'h0;
    int ccnt = -1;
    int cbank = 0;
    bit mvalid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lane(input logic [1:0] c, input logic [31:0] v);
        return c == 2'd1 ? (v & 32'hFF) : c == 2'd2 ? (v & 32'hFFFF) : v;
    endfunction

    function automatic logic [31:0] exp_rd(input int a);
        logic [31:0] v;
        v = (bus.supervisor && a == 15) ? mssp : mb[bus.bank_sel][a];
`ifdef REGFILE_BYPASS_EN
        if (bus.wr_en != 0 && a == int'(bus.wr_addr)) v = lane(bus.wr_en, bus.wr_data);
        if (bus.sp_en != 0 && a == 15) v = lane(bus.sp_en, bus.sp_data_i);
`endif
        return v;
    endfunction

    function automatic logic [31:0] exp_sp();
        logic [31:0] v;
        v = bus.supervisor ? mssp : mb[bus.bank_sel][15];
`ifdef REGFILE_BYPASS_EN
        if (bus.wr_en != 0 && bus.wr_addr == 4'd15) v = lane(bus.wr_en, bus.wr_data);
        if (bus.sp_en != 0) v = lane(bus.sp_en, bus.sp_data_i);
`endif
        return v;
    endfunction

    function automatic logic [31:0] rd(input int k);
        return bus.rd_data[k*32 +: 32];
    endfunction

    // Model: a clear started at count 0 zeroes index ccnt while ccnt<16; ccnt==16 is the done cycle.
    always @(posedge clk) begin
        if (rst) begin
            mvalid = 1'b1;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 16; i++)
                    mb[b][i] = 32'h0;
            mssp = 32'h0;
            ccnt = -1;
        end else begin
            if (ccnt >= 0 && ccnt < 16) mb[cbank][ccnt] = 32'h0;
            if (bus.wr_en != 0) begin
                if (bus.supervisor && bus.wr_addr == 4'd15) mssp = lane(bus.wr_en, bus.wr_data);
                else mb[bus.bank_sel][bus.wr_addr] = lane(bus.wr_en, bus.wr_data);
            end
            if (bus.sp_en != 0) begin
                if (bus.supervisor) mssp = lane(bus.sp_en, bus.sp_data_i);
                else mb[bus.bank_sel][15] = lane(bus.sp_en, bus.sp_data_i);
            end
            if (ccnt == 16) ccnt = -1;
            else if (ccnt >= 0) ccnt++;
            else if (bus.clr_req) begin
                ccnt = 0;
                cbank = int'(bus.clr_bank);
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int k = 0; k < 3; k++)
                chk($sformatf("rd%0d", k), rd(k), exp_rd(int'(bus.rd_addr[k*4 +: 4])));
            chk("sp_data_o", bus.sp_data_o, exp_sp());
            chk("clr_busy", 32'(bus.clr_busy), 32'(ccnt >= 0));
            chk("clr_done", 32'(bus.clr_done), 32'(ccnt == 16));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [1:0] en);
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_en = en;
    endtask

    task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        bus.rd_addr = {a2, a1, a0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n, done_at, waited;
        bit done_seen;
        bus.supervisor = 0; bus.bank_sel = 0; bus.rd_addr = 0;
        bus.wr_addr = 0; bus.wr_data = 0; bus.wr_en = 0;
        bus.sp_data_i = 0; bus.sp_en = 0; bus.clr_req = 0; bus.clr_bank = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        look();
        chk("lit_reset_rd", rd(0), 32'h0);
        chk("lit_reset_sp", bus.sp_data_o, 32'h0);
        chk("lit_reset_busy", 32'(bus.clr_busy), 32'h0);

        bus.bank_sel = 1; wr(3, 32'hDEADBEEF, 3); tick();
        bus.wr_en = 0; bus.bank_sel = 0; set_rd(3, 3, 3);
        look(); chk("lit_bank0_r3", rd(0), 32'h0); tick();
        bus.bank_sel = 1;
        look(); chk("lit_bank1_r3", rd(1), 32'hDEADBEEF); tick();

        wr(2, 32'h12345678, 1); tick();
        bus.wr_en = 0; set_rd(2, 2, 2);
        look(); chk("lit_byte", rd(0), 32'h00000078); tick();
        wr(2, 32'h12345678, 2); tick();
        bus.wr_en = 0;
        look(); chk("lit_half", rd(2), 32'h00005678); tick();

        wr(15, 32'h777, 3); tick();
        bus.supervisor = 1; wr(15, 32'h2000, 3); bus.sp_en = 3; bus.sp_data_i = 32'h1000; tick();
        bus.wr_en = 0; bus.sp_en = 0; set_rd(15, 15, 15);
        look(); chk("lit_ssp", bus.sp_data_o, 32'h1000); chk("lit_rd_ssp", rd(2), 32'h1000); tick();
        bus.supervisor = 0;
        look(); chk("lit_user_sp", bus.sp_data_o, 32'h777); chk("lit_rd_user_sp", rd(0), 32'h777); tick();

        set_rd(4, 4, 4); wr(4, 32'hA5, 3);
        look();
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < 3; k++) chk($sformatf("lit_bypass%0d", k), rd(k), 32'hA5);
`else
        for (int k = 0; k < 3; k++) chk($sformatf("lit_nobypass%0d", k), rd(k), 32'h0);
`endif
        tick();
        bus.wr_en = 0;
        look();
        for (int k = 0; k < 3; k++) chk($sformatf("lit_after%0d", k), rd(k), 32'hA5);
        tick();

        bus.bank_sel = 0;
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), 32'h11111111 * 32'(i + 1), 3);
            tick();
        end
        bus.wr_en = 0; bus.clr_req = 1; bus.clr_bank = 0; tick();
        bus.clr_req = 0; busy_n = 0; done_at = -1;
        for (int j = 0; j < 20; j++) begin
            if (j == 15) wr(15, 32'hBEEF0015, 3);
            else bus.wr_en = 0;
            look();
            if (bus.clr_busy) busy_n++;
            if (bus.clr_done) done_at = j;
            tick();
        end
        chk("lit_busy_len", 32'(busy_n), 32'd17);
        chk("lit_done_at", 32'(done_at), 32'd16);
        set_rd(0, 7, 15);
        look();
        chk("lit_clr_r0", rd(0), 32'h0);
        chk("lit_clr_r7", rd(1), 32'h0);
        chk("lit_clr_r15_kept", rd(2), 32'hBEEF0015);
        tick();
        bus.supervisor = 1;
        look(); chk("lit_ssp_untouched", bus.sp_data_o, 32'h1000); tick();
        bus.supervisor = 0;

        bus.bank_sel = 1; set_rd(2, 4, 15);
        bus.clr_req = 1; bus.clr_bank = 1; tick();
        bus.clr_req = 0; done_seen = 0;
        for (int j = 0; j < 5; j++) begin
            look(); done_seen |= bus.clr_done; tick();
        end
        rst = 1;
        look(); tick();
        rst = 0; bus.clr_req = 1;
        look();
        chk("lit_rst_busy", 32'(bus.clr_busy), 32'h0);
        chk("lit_rst_rd0", rd(0), 32'h0);
        chk("lit_rst_rd1", rd(1), 32'h0);
        chk("lit_rst_sp", bus.sp_data_o, 32'h0);
        tick();
        look(); chk("lit_reaccept", 32'(bus.clr_busy), 32'h1); tick();
        for (int j = 0; j < 20; j++) tick();
        bus.clr_req = 0;
        waited = 0;
        while (bus.clr_busy && waited < 40) begin
            tick();
            waited++;
        end
        chk("lit_idle_timeout", 32'(bus.clr_busy), 32'h0);
        chk("lit_no_done_on_reset", 32'(done_seen), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
